uart_rx_par: RTL and testbench
==============================

Name: uart_rx_par

Overview:
Next-generation UART receiver with runtime parity and stop-bit configuration, 3-sample majority voting and an internal sample-rate divider. It adds per-frame error flags and a valid/ready output handshake with overrun detection. It sits between the pad-side rx line and a byte consumer such as a FIFO or SPI/UART bridge logic, and replaces the basic receiver wherever error reporting or back-pressure is needed.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9
OVERSAMPLING, 16, sample ticks per bit; legal values even and >=8
CLKS_PER_SAMPLE, 1, clk cycles per sample tick; legal values >=1 (1 = every clk)
SYNC_STAGES, 2, rx synchroniser depth; legal values >=2

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
rx  in  1  serial line; asynchronous; idles high
parity_en  in  1  1 = frame carries a parity bit after the data bits
parity_odd  in  1  1 = odd parity, 0 = even parity; ignored when parity_en=0
two_stop  in  1  1 = two stop bits, 0 = one stop bit
ready_in  in  1  consumer accepts data_out when high together with valid_out
data_out  out  DATA_BITS  received word, LSB first on the line
valid_out  out  1  data_out and the error flags hold a frame
parity_err  out  1  parity mismatch for the frame held in data_out
frame_err  out  1  a stop bit sampled low for the frame held in data_out
overrun  out  1  one-cycle pulse: completed frame dropped because the holding register was full
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: FSM=IDLE; synchroniser flops=1; data_out=0; valid_out=parity_err=frame_err=overrun=busy=0; all counters=0. Reset mid-frame aborts the frame with no output.
- Tick: divider counts 0..CLKS_PER_SAMPLE-1 and emits tick for one clk at terminal count. FSM sample counter, bit counter and vote logic advance only on tick.
- rx passes through SYNC_STAGES flops to give rx_s. All decisions use rx_s.
- Config latch: parity_en, parity_odd and two_stop are latched on the IDLE->START transition. Changing them mid-frame has no effect on the current frame.
- Vote: in each bit period the receiver samples rx_s at sample counts M-1, M and M+1, where M = OVERSAMPLING/2. The bit value is the majority of the 3 samples and is resolved at sample count M+1.
- IDLE: on a tick with rx_s=0, clear the sample counter and go to START.
- START: at the vote, majority 1 means a false start; go to IDLE with no flags. Majority 0 means proceed. At sample count OVERSAMPLING-1, go to DATA with bit_cnt=0.
- DATA: at each vote, shift the value in from the MSB side (LSB arrives first). At the end of the bit period (count OVERSAMPLING-1), increment bit_cnt. After bit DATA_BITS-1, go to PARITY if parity_en=1, else STOP.
- PARITY: the voted bit is checked against the parity of the data. Expected bit = XOR(data) for even parity, ~XOR(data) for odd parity. A mismatch sets the internal p_err. At the end of the period, go to STOP.
- STOP: one period, or two if two_stop=1. A voted 0 in any stop period sets the internal f_err. At the vote of the last stop bit, the frame completes and FSM goes to IDLE immediately, without waiting for the period end, so back-to-back frames resynchronise.
- Completion: on the completing tick, if valid_out=0 or ready_in=1, load data_out, parity_err=p_err and frame_err=f_err, and set valid_out=1 on the next clk. Otherwise discard the frame, leave data_out and flags unchanged, and pulse overrun for 1 clk.
- Handshake: valid_out stays high until valid_out&&ready_in. In that cycle, with no completion, valid_out clears next clk. data_out and the flags are held stable while valid_out=1.
- Internal p_err and f_err clear on entry to START.
- Frame length in ticks: OVERSAMPLING*(1+DATA_BITS+parity_en) plus the stop portion up to the last vote.

Decomposition:
- Shared package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP); parity-mode constants; localparam function for counter widths ($clog2(OVERSAMPLING), $clog2(DATA_BITS)).
- One sub-module, uart_sample_tick: the CLKS_PER_SAMPLE divider with an enable output. It is reusable by the matching transmitter.

Test Plan:
- Default params, parity_en=0, two_stop=0; send 0xA5 at 16 clk/bit, ready_in=1 -> valid_out pulses 1 clk, data_out=0xA5, parity_err=0, frame_err=0.
- parity_en=1, parity_odd=0; send 0x03 with parity bit 1 (wrong) -> data_out=0x03, parity_err=1. Repeat with parity bit 0 -> parity_err=0.
- two_stop=1; send 0x5A with second stop bit driven low -> frame_err=1, data_out=0x5A.
- rx glitch low for 4 clk, then high -> FSM returns to IDLE, busy falls, valid_out stays 0. A single-sample 1-glitch at mid data bit is voted out -> correct byte 0x81.
- ready_in=0; send 0x11 then 0x22 -> data_out=0x11 held with valid_out=1, overrun pulses once at 0x22 completion. Raise ready_in -> valid_out clears.
- CLKS_PER_SAMPLE=4, DATA_BITS=7; send 0x7F -> data_out=0x7F after 64 clk per bit. Assert n_rst mid-frame -> all outputs 0 and the next frame is received cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity-mode encodings and
// a counter-width helper used by the receiver and the sample-tick divider.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_par_if.sv
// Receive-side byte handshake: the receiver (master) offers a word plus its
// error flags, the consumer (slave) answers with ready_in.
interface uart_rx_par_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 valid_out;
  logic                 ready_in;
  logic                 parity_err;
  logic                 frame_err;

  modport master (output data_out, valid_out, parity_err, frame_err, input ready_in);
  modport slave  (input data_out, valid_out, parity_err, frame_err, output ready_in);
endinterface

// File: rtl/uart_sample_tick.sv
// Sample-rate divider: one-clk tick every CLKS_PER_SAMPLE clocks.
// Shared with the matching transmitter.
module uart_sample_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_SAMPLE = 1
)(
  input  logic clk,
  input  logic n_rst,
  output logic tick
);

  localparam int CW = cnt_w(CLKS_PER_SAMPLE);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_SAMPLE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // With CLKS_PER_SAMPLE=1 the counter sits at 0 and tick stays high.
  assign tick = (cnt_q == C_LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_par.sv
// UART receiver with runtime parity/stop config, 3-sample majority vote,
// error flags and a valid/ready holding register with overrun detection.
module uart_rx_par
  import uart_pkg::*;
#(
  parameter int DATA_BITS       = 8,
  parameter int OVERSAMPLING    = 16,
  parameter int CLKS_PER_SAMPLE = 1,
  parameter int SYNC_STAGES     = 2
)(
  input  logic          clk,
  input  logic          n_rst,
  input  logic          rx,
  input  logic          parity_en,
  input  logic          parity_odd,
  input  logic          two_stop,
  output logic          overrun,
  output logic          busy,
  uart_rx_par_if.master rx_if
);

  localparam int SW = cnt_w(OVERSAMPLING);
  localparam int BW = cnt_w(DATA_BITS);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLING - 1);
  localparam logic [SW-1:0] S_M1   = SW'(OVERSAMPLING / 2 - 1);
  localparam logic [SW-1:0] S_M    = SW'(OVERSAMPLING / 2);
  localparam logic [SW-1:0] S_P1   = SW'(OVERSAMPLING / 2 + 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic tick;

  uart_sample_tick #(.CLKS_PER_SAMPLE(CLKS_PER_SAMPLE)) u_tick (
    .clk   (clk),
    .n_rst (n_rst),
    .tick  (tick)
  );

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SW-1:0]          samp_q, samp_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic                   stop_q, stop_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   s0_q, s0_d, s1_q, s1_d;
  logic                   cfg_par_q, cfg_par_d, cfg_odd_q, cfg_odd_d, cfg_two_q, cfg_two_d;
  logic                   p_err_q, p_err_d, f_err_q, f_err_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
  logic                   ovr_q, ovr_d, busy_q, busy_d;

  logic rx_s, maj, is_vote, is_last, complete;

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign maj     = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
  assign is_vote = (samp_q == S_P1);
  assign is_last = (samp_q == S_LAST);

  always_comb begin
    state_d   = state_q;
    sync_d    = {sync_q[SYNC_STAGES-2:0], rx};
    samp_d    = samp_q;
    bit_d     = bit_q;
    stop_d    = stop_q;
    shreg_d   = shreg_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    cfg_par_d = cfg_par_q;
    cfg_odd_d = cfg_odd_q;
    cfg_two_d = cfg_two_q;
    p_err_d   = p_err_q;
    f_err_d   = f_err_q;
    data_d    = data_q;
    valid_d   = valid_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    ovr_d     = 1'b0;
    complete  = 1'b0;

    if (valid_q && rx_if.ready_in) valid_d = 1'b0;

    if (tick && state_q != IDLE) begin
      samp_d = is_last ? '0 : samp_q + SW'(1);
      if (samp_q == S_M1) s0_d = rx_s;
      if (samp_q == S_M)  s1_d = rx_s;
    end

    if (tick) begin
      case (state_q)
        IDLE: if (!rx_s) begin
          state_d   = START;
          samp_d    = '0;
          cfg_par_d = parity_en;
          cfg_odd_d = parity_odd;
          cfg_two_d = two_stop;
          p_err_d   = 1'b0;
          f_err_d   = 1'b0;
        end
        START: begin
          if (is_vote && maj) state_d = IDLE;
          else if (is_last) begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
        DATA: begin
          if (is_vote) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
          if (is_last) begin
            if (bit_q == B_LAST) begin
              state_d = cfg_par_q ? PARITY : STOP;
              stop_d  = 1'b0;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end
        end
        PARITY: begin
          if (is_vote && (maj != (^shreg_q ^ cfg_odd_q))) p_err_d = 1'b1;
          if (is_last) begin
            state_d = STOP;
            stop_d  = 1'b0;
          end
        end
        STOP: begin
          if (is_vote) begin
            if (!maj) f_err_d = 1'b1;
            if (stop_q == cfg_two_q) complete = 1'b1;
          end
          if (is_last) stop_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    // Finish on the last stop vote so a following start edge is caught early.
    if (complete) begin
      state_d = IDLE;
      if (!valid_q || rx_if.ready_in) begin
        data_d  = shreg_q;
        perr_d  = p_err_q;
        ferr_d  = f_err_q | ~maj;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      sync_q    <= '1;
      samp_q    <= '0;
      bit_q     <= '0;
      stop_q    <= 1'b0;
      shreg_q   <= '0;
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      cfg_par_q <= 1'b0;
      cfg_odd_q <= 1'b0;
      cfg_two_q <= 1'b0;
      p_err_q   <= 1'b0;
      f_err_q   <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      samp_q    <= samp_d;
      bit_q     <= bit_d;
      stop_q    <= stop_d;
      shreg_q   <= shreg_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      cfg_par_q <= cfg_par_d;
      cfg_odd_q <= cfg_odd_d;
      cfg_two_q <= cfg_two_d;
      p_err_q   <= p_err_d;
      f_err_q   <= f_err_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      busy_q    <= busy_d;
    end
  end

  assign rx_if.data_out   = data_q;
  assign rx_if.valid_out  = valid_q;
  assign rx_if.parity_err = perr_q;
  assign rx_if.frame_err  = ferr_q;
  assign overrun          = ovr_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_uart_rx_par.sv
// Directed bench: default-parameter receiver (a) plus a 7-bit, /4 divider
// receiver (b); a negedge monitor records accepted words and overrun pulses.
module tb_uart_rx_par;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1;
  logic par_en = 1'b0, par_odd = 1'b0, two_stop = 1'b0;
  logic ovr_a, ovr_b, busy_a, busy_b;

  int errors = 0;
  int checks = 0;

  int         acc_a_cnt = 0, ovr_a_cnt = 0, acc_b_cnt = 0;
  logic [7:0] acc_a_data = '0;
  logic [6:0] acc_b_data = '0;
  logic       acc_a_pe = 1'b0, acc_a_fe = 1'b0, acc_b_fe = 1'b0;

  uart_rx_par_if #(.DATA_BITS(8)) if_a ();
  uart_rx_par_if #(.DATA_BITS(7)) if_b ();

  uart_rx_par #(.DATA_BITS(8), .OVERSAMPLING(16), .CLKS_PER_SAMPLE(1), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .n_rst(n_rst), .rx(rx_a), .parity_en(par_en), .parity_odd(par_odd),
    .two_stop(two_stop), .overrun(ovr_a), .busy(busy_a), .rx_if(if_a)
  );

  uart_rx_par #(.DATA_BITS(7), .OVERSAMPLING(16), .CLKS_PER_SAMPLE(4), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .n_rst(n_rst), .rx(rx_b), .parity_en(par_en), .parity_odd(par_odd),
    .two_stop(two_stop), .overrun(ovr_b), .busy(busy_b), .rx_if(if_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (if_a.valid_out && if_a.ready_in) begin
      acc_a_cnt++;
      acc_a_data = if_a.data_out;
      acc_a_pe   = if_a.parity_err;
      acc_a_fe   = if_a.frame_err;
    end
    if (ovr_a) ovr_a_cnt++;
    if (if_b.valid_out && if_b.ready_in) begin
      acc_b_cnt++;
      acc_b_data = if_b.data_out;
      acc_b_fe   = if_b.frame_err;
    end
  end

  // Drive n frame bits (LSB first), cpb clocks each; optionally invert one clock.
  task automatic send(input bit sel, input logic [15:0] bits, input int n, input int cpb,
                      input int gbit, input int gcyc);
    logic v;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < cpb; c++) begin
        @(posedge clk); #1;
        v = bits[i];
        if (i == gbit && c == gcyc) v = ~v;
        if (sel) rx_b = v; else rx_a = v;
      end
    end
    @(posedge clk); #1;
    if (sel) rx_b = 1'b1; else rx_a = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (if_a.valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", if_a.valid_out); end
    checks++; if (if_a.data_out !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", if_a.data_out); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_a); end
    checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL rst_ovr: got %b want 0", ovr_a); end
    checks++; if ({if_a.parity_err, if_a.frame_err} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b want 00", {if_a.parity_err, if_a.frame_err}); end
  endtask

  task automatic test_basic();
    int c0 = acc_a_cnt;
    send(1'b0, 16'({1'b1, 8'hA5, 1'b0}), 10, 16, -1, 0);
    checks++; if (acc_a_cnt - c0 !== 1) begin errors++; $display("FAIL basic_cnt: got %0d want 1", acc_a_cnt - c0); end
    checks++; if (acc_a_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", acc_a_data); end
    checks++; if ({acc_a_pe, acc_a_fe} !== 2'b00) begin errors++; $display("FAIL basic_flags: got %b want 00", {acc_a_pe, acc_a_fe}); end
    checks++; if (if_a.valid_out !== 1'b0) begin errors++; $display("FAIL basic_vclr: got %b want 0", if_a.valid_out); end
  endtask

  task automatic test_parity();
    par_en = 1'b1; par_odd = 1'b0;
    send(1'b0, 16'({1'b1, 1'b1, 8'h03, 1'b0}), 11, 16, -1, 0);
    checks++; if (acc_a_data !== 8'h03) begin errors++; $display("FAIL par_bad_data: got %h want 03", acc_a_data); end
    checks++; if (acc_a_pe !== 1'b1) begin errors++; $display("FAIL par_bad_pe: got %b want 1", acc_a_pe); end
    send(1'b0, 16'({1'b1, 1'b0, 8'h03, 1'b0}), 11, 16, -1, 0);
    checks++; if (acc_a_pe !== 1'b0) begin errors++; $display("FAIL par_good_pe: got %b want 0", acc_a_pe); end
    par_odd = 1'b1;
    send(1'b0, 16'({1'b1, 1'b1, 8'h03, 1'b0}), 11, 16, -1, 0);
    checks++; if (acc_a_pe !== 1'b0) begin errors++; $display("FAIL par_odd_pe: got %b want 0", acc_a_pe); end
    par_en = 1'b0; par_odd = 1'b0;
  endtask

  task automatic test_two_stop();
    two_stop = 1'b1;
    send(1'b0, 16'({1'b0, 1'b1, 8'h5A, 1'b0}), 11, 16, -1, 0);
    checks++; if (acc_a_data !== 8'h5A) begin errors++; $display("FAIL stop2_data: got %h want 5a", acc_a_data); end
    checks++; if (acc_a_fe !== 1'b1) begin errors++; $display("FAIL stop2_fe: got %b want 1", acc_a_fe); end
    two_stop = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL stop2_idle: got %b want 0", busy_a); end
  endtask

  task automatic test_glitch();
    int c0 = acc_a_cnt;
    @(posedge clk); #1; rx_a = 1'b0;
    repeat (4) @(posedge clk);
    #1; rx_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL glitch_busy: got %b want 1", busy_a); end
    repeat (40) @(posedge clk);
    #1;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL glitch_idle: got %b want 0", busy_a); end
    checks++; if (acc_a_cnt !== c0 || if_a.valid_out !== 1'b0) begin errors++; $display("FAIL glitch_novalid: got cnt %0d want %0d", acc_a_cnt, c0); end
    send(1'b0, 16'({1'b1, 8'h81, 1'b0}), 10, 16, 2, 9);
    checks++; if (acc_a_data !== 8'h81) begin errors++; $display("FAIL vote_data: got %h want 81", acc_a_data); end
  endtask

  task automatic test_back_to_back();
    int o0 = ovr_a_cnt;
    if_a.ready_in = 1'b0;
    send(1'b0, 16'({1'b1, 8'h11, 1'b0}), 10, 16, -1, 0);
    checks++; if (if_a.valid_out !== 1'b1 || if_a.data_out !== 8'h11) begin errors++; $display("FAIL hold_first: got v=%b d=%h want v=1 d=11", if_a.valid_out, if_a.data_out); end
    send(1'b0, 16'({1'b1, 8'h22, 1'b0}), 10, 16, -1, 0);
    checks++; if (ovr_a_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_pulse: got %0d want 1", ovr_a_cnt - o0); end
    checks++; if (if_a.valid_out !== 1'b1 || if_a.data_out !== 8'h11) begin errors++; $display("FAIL ovr_hold: got v=%b d=%h want v=1 d=11", if_a.valid_out, if_a.data_out); end
    if_a.ready_in = 1'b1;
    @(posedge clk); #1;
    checks++; if (if_a.valid_out !== 1'b0) begin errors++; $display("FAIL ready_clr: got %b want 0", if_a.valid_out); end
    checks++; if (acc_a_data !== 8'h11) begin errors++; $display("FAIL ready_data: got %h want 11", acc_a_data); end
  endtask

  task automatic test_div_b();
    int c0 = acc_b_cnt;
    send(1'b1, 16'({1'b1, 7'h7F, 1'b0}), 9, 64, -1, 0);
    checks++; if (acc_b_cnt - c0 !== 1) begin errors++; $display("FAIL div_cnt: got %0d want 1", acc_b_cnt - c0); end
    checks++; if (acc_b_data !== 7'h7F || acc_b_fe !== 1'b0) begin errors++; $display("FAIL div_data: got %h fe=%b want 7f fe=0", acc_b_data, acc_b_fe); end
  endtask

  task automatic test_reset_mid();
    int c0;
    @(posedge clk); #1; rx_b = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy_b); end
    n_rst = 1'b0; rx_b = 1'b1;
    #2;
    checks++; if (busy_b !== 1'b0 || if_b.valid_out !== 1'b0 || if_b.data_out !== 7'h00 || ovr_b !== 1'b0) begin errors++; $display("FAIL mid_rst: got b=%b v=%b d=%h o=%b want all 0", busy_b, if_b.valid_out, if_b.data_out, ovr_b); end
    repeat (3) @(posedge clk);
    #1; n_rst = 1'b1;
    repeat (8) @(posedge clk);
    c0 = acc_b_cnt;
    send(1'b1, 16'({1'b1, 7'h2A, 1'b0}), 9, 64, -1, 0);
    checks++; if (acc_b_cnt - c0 !== 1 || acc_b_data !== 7'h2A) begin errors++; $display("FAIL post_rst: got cnt=%0d d=%h want 1 2a", acc_b_cnt - c0, acc_b_data); end
  endtask

  initial begin
    if_a.ready_in = 1'b1;
    if_b.ready_in = 1'b1;
    repeat (3) @(posedge clk);
    test_reset();
    #1; n_rst = 1'b1;
    repeat (5) @(posedge clk);
    test_basic();
    test_parity();
    test_two_stop();
    test_glitch();
    test_back_to_back();
    test_div_b();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
